wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources:
  - the in-order pipeline writeback, taken from the MEM/WB stage outputs;
  - a long-latency unit (divider/CSR) that returns results asynchronously.
- Pipeline writeback has priority.
- The long-latency result is held in a 1-entry buffer. If it is starved too long, the block stalls the pipeline for one cycle to drain it.
- Sits between the MEM/WB register, the long-latency unit, the regfile write port and the pipeline ctrl block.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, register address width.
- MAX_WAIT, 4, consecutive lost arbitration cycles before forcing a drain. Legal range 1..7.
- CNT_W, 3, starvation counter width. Must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- wb_rd  in  ADDR_W  pipeline destination register.
- wb_regwe  in  1  pipeline write enable.
- wb_wdata  in  DATA_W  pipeline write data.
- lu_valid  in  1  long-unit result valid.
- lu_rd  in  ADDR_W  long-unit destination register.
- lu_wdata  in  DATA_W  long-unit result data.
- lu_ready  out  1  buffer can accept.
- reg_we_o  out  1  regfile write enable.
- reg_waddr_o  out  ADDR_W  regfile write address.
- reg_wdata_o  out  DATA_W  regfile write data.
- stall_o  out  1  pipeline hold request to ctrl.
- busy_o  out  1  buffer occupied.
- perf_stall_cnt_o  out  32  forced-stall count (see Optional Feature).

Behaviour:
- Reset, clock: rst synchronous, active-high; clock clk.
  - On reset: reg_we_o=0, reg_waddr_o=0, reg_wdata_o=0, stall_o=0, buffer empty (busy_o=0, lu_ready=1), counter=0, FSM=IDLE.
  - Reset mid-operation silently discards any buffered result.
- Definitions:
  - Pipeline write request: pw = wb_regwe & (wb_rd != 0).
  - Buffer accept: lu_valid & lu_ready.
  - An accept with lu_rd==0 is consumed and dropped; the buffer stays empty.
- lu_ready = ~buf_valid, driven from the registered flag. No accept is possible in the same cycle the buffer drains.
- Write port outputs are registered, latency 1: the grant decided in cycle N is visible on reg_* in cycle N+1.
  - Regfile forwarding accounts for this extra cycle.
  - reg_we_o=0 whenever nothing is granted; address and data then hold their last values.
- FSM (Moore; stall_o=1 only in FORCE):
  - IDLE: buffer empty. Pipeline granted when pw. Accept moves to WAIT.
  - WAIT: buffer full.
    - If pw: pipeline granted and counter increments. When counter==MAX_WAIT-1 on a lost cycle, next state is FORCE.
    - If !pw: buffer granted, buffer cleared, counter cleared, next state IDLE.
  - FORCE: buffer granted unconditionally; the pipeline write is NOT performed (upstream holds MEM/WB because stall_o=1); buffer and counter cleared; next state IDLE.
- WAW rule: if the pipeline is granted with wb_rd == buffered rd, the buffered entry is dropped (the pipeline value is younger). FSM goes to IDLE and the counter is cleared.
- The scoreboard in issue logic guarantees no other WAW hazard between the two sources.
- Minimum buffer path: accept in cycle N, grant at N+1, reg_we_o high at N+2.
- Simultaneous accept and pipeline write in IDLE: both occur; the buffer is then contended starting next cycle.

Optional Feature:
- Macro: WB_ARB_PERF_EN.
- Defined: a 32-bit counter increments on every cycle the FSM is in FORCE. It clears on rst, saturates at 0xFFFFFFFF, and drives perf_stall_cnt_o.
- Undefined: no counter logic is present; perf_stall_cnt_o is tied to 0.

Decomposition:
- Shared package (define.vh):
  - RegAddrBus, RegBus, NopRegAddr, Zero, Enabled/Disabled.
  - New FSM state encodings WB_ARB_IDLE/WAIT/FORCE (2-bit).
- Sub-module wb_skid_buf: 1-entry valid/ready buffer with load, clear and a drop-on-match input.

Test Plan:
- Reset mid-WAIT with buffer holding rd=7 -> after rst: busy_o=0, lu_ready=1, reg_we_o=0, stall_o=0.
- Pipeline idle; lu_valid with rd=3, data=0xDEAD0001 at cycle N -> reg_we_o=1, waddr=3, wdata=0xDEAD0001 at N+2; lu_ready back to 1 at N+2.
- MAX_WAIT=4; buffer holds rd=5; pw every cycle to rd=9 -> 4 pipeline writes, then stall_o=1 for exactly 1 cycle with reg_waddr_o=5 next cycle; the held pipeline write to rd=9 completes the cycle after.
- Buffer holds rd=6, data=0x11; pipeline writes rd=6, data=0x22 -> regfile sees only 0x22; busy_o falls; no stall.
- lu_valid with lu_rd=0 -> no write ever issued; busy_o stays 0.
- WB_ARB_PERF_EN defined, 3 forced drains -> perf_stall_cnt_o=3. Undefined -> perf_stall_cnt_o=0.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Holds the arbiter FSM state encoding and the common register-bus definitions.
package wb_port_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t NOP_REG_ADDR = '0;
  localparam reg_data_t ZERO_WORD    = '0;
  localparam logic      ENABLED      = 1'b1;
  localparam logic      DISABLED     = 1'b0;

  typedef enum logic [1:0] {
    WB_ARB_IDLE  = 2'd0,
    WB_ARB_WAIT  = 2'd1,
    WB_ARB_FORCE = 2'd2
  } wb_arb_state_e;

endpackage

// File: rtl/wb_skid_buf.sv
// One-entry valid/ready holding buffer for long-latency results.
// Loads only when empty; clears on grant or when a younger write hits the same rd.
module wb_skid_buf
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_clear,
  input  logic              i_drop,
  input  logic [ADDR_W-1:0] i_drop_rd,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_rd,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_data;
  logic              w_drop_hit;

  assign w_drop_hit = i_drop & (i_drop_rd == r_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= DISABLED;
      r_rd    <= '0;
      r_data  <= '0;
    end else if (i_load & ~r_valid) begin
      r_valid <= ENABLED;
      r_rd    <= i_rd;
      r_data  <= i_data;
    end else if (i_clear | w_drop_hit) begin
      r_valid <= DISABLED;
    end
  end

  assign o_valid = r_valid;
  assign o_rd    = r_rd;
  assign o_data  = r_data;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between MEM/WB writeback (priority) and a buffered
// long-latency result, forcing a one-cycle stall when the buffer starves. Optional: WB_ARB_PERF_EN.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              wb_regwe,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_rd,
  input  logic [DATA_W-1:0] lu_wdata,
  output logic              lu_ready,
  output logic              reg_we_o,
  output logic [ADDR_W-1:0] reg_waddr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              stall_o,
  output logic              busy_o,
  output logic [31:0]       perf_stall_cnt_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

  wb_arb_state_e     r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_stall;

  logic              w_pw;
  logic              w_load;
  logic              w_grant_pipe;
  logic              w_grant_buf;
  logic              w_in_wait;
  logic              w_waw;
  logic              w_buf_valid;
  logic [ADDR_W-1:0] w_buf_rd;
  logic [DATA_W-1:0] w_buf_data;

  assign w_pw      = wb_regwe & (wb_rd != '0);
  // rd==0 accepts are consumed here but never stored
  assign w_load    = lu_valid & ~w_buf_valid & (lu_rd != '0);
  assign w_in_wait = (r_state == WB_ARB_WAIT);
  assign w_waw     = w_in_wait & w_pw & (wb_rd == w_buf_rd);

  always_comb begin
    w_grant_pipe = 1'b0;
    w_grant_buf  = 1'b0;
    case (r_state)
      WB_ARB_IDLE:  w_grant_pipe = w_pw;
      WB_ARB_WAIT: begin
        w_grant_pipe = w_pw;
        w_grant_buf  = ~w_pw;
      end
      WB_ARB_FORCE: w_grant_buf = 1'b1;
      default: ;
    endcase
  end

  wb_skid_buf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_rd     (lu_rd),
    .i_data   (lu_wdata),
    .i_clear  (w_grant_buf),
    .i_drop   (w_in_wait & w_grant_pipe),
    .i_drop_rd(wb_rd),
    .o_valid  (w_buf_valid),
    .o_rd     (w_buf_rd),
    .o_data   (w_buf_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WB_ARB_IDLE;
      r_cnt   <= '0;
      r_we    <= DISABLED;
      r_waddr <= '0;
      r_wdata <= '0;
      r_stall <= DISABLED;
    end else begin
      r_we    <= w_grant_pipe | w_grant_buf;
      r_stall <= DISABLED;
      if (w_grant_pipe) begin
        r_waddr <= wb_rd;
        r_wdata <= wb_wdata;
      end else if (w_grant_buf) begin
        r_waddr <= w_buf_rd;
        r_wdata <= w_buf_data;
      end
      case (r_state)
        WB_ARB_IDLE: begin
          if (w_load) begin
            r_state <= WB_ARB_WAIT;
            r_cnt   <= '0;
          end
        end
        WB_ARB_WAIT: begin
          if (w_waw || !w_pw) begin
            r_state <= WB_ARB_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == LAST_CNT) begin
            r_state <= WB_ARB_FORCE;
            r_stall <= ENABLED;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WB_ARB_FORCE: begin
          r_state <= WB_ARB_IDLE;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= WB_ARB_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign lu_ready    = ~w_buf_valid;
  assign busy_o      = w_buf_valid;
  assign reg_we_o    = r_we;
  assign reg_waddr_o = r_waddr;
  assign reg_wdata_o = r_wdata;
  assign stall_o     = r_stall;

`ifdef WB_ARB_PERF_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf <= '0;
    end else if ((r_state == WB_ARB_FORCE) && (r_perf != '1)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_stall_cnt_o = r_perf;
`else
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed stimulus pushes expected regfile
// writes; a negedge monitor pops and compares every reg_we_o pulse.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wb_rd;
  logic        wb_regwe;
  logic [31:0] wb_wdata;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic        stall_o;
  logic        busy_o;
  logic [31:0] perf_stall_cnt_o;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  forced = 0;

  wb_port_arbiter #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .MAX_WAIT(4),
    .CNT_W   (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wb_rd           (wb_rd),
    .wb_regwe        (wb_regwe),
    .wb_wdata        (wb_wdata),
    .lu_valid        (lu_valid),
    .lu_rd           (lu_rd),
    .lu_wdata        (lu_wdata),
    .lu_ready        (lu_ready),
    .reg_we_o        (reg_we_o),
    .reg_waddr_o     (reg_waddr_o),
    .reg_wdata_o     (reg_wdata_o),
    .stall_o         (stall_o),
    .busy_o          (busy_o),
    .perf_stall_cnt_o(perf_stall_cnt_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_we_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %08h, required no write",
                 reg_waddr_o, reg_wdata_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (reg_waddr_o !== mon_e.addr || reg_wdata_o !== mon_e.data) begin
          errors++;
          $display("FAIL regfile_write: got addr %0d data %08h, required addr %0d data %08h",
                   reg_waddr_o, reg_wdata_o, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    wb_regwe = 1'b0;
    wb_rd    = '0;
    wb_wdata = '0;
    lu_valid = 1'b0;
    lu_rd    = '0;
    lu_wdata = '0;
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  // Buffer rd=5, then pipeline writes rd=9 every cycle until the forced drain.
  task automatic starve(input logic [31:0] base);
    idle_in();
    lu_valid = 1'b1;
    lu_rd    = 5'd5;
    lu_wdata = base + 32'h55;
    clk1();
    lu_valid = 1'b0;
    chk("starve_busy_loaded", busy_o, 1);
    for (int k = 0; k < 4; k++) begin
      wb_regwe = 1'b1;
      wb_rd    = 5'd9;
      wb_wdata = base + k;
      expect_wr(5'd9, base + k);
      clk1();
      chk("starve_stall", stall_o, (k == 3) ? 1 : 0);
    end
    wb_wdata = base + 32'd4;
    expect_wr(5'd5, base + 32'h55);
    clk1();
    chk("starve_stall_one_cycle", stall_o, 0);
    chk("starve_busy_drained", busy_o, 0);
    expect_wr(5'd9, base + 32'd4);
    clk1();
    idle_in();
    clk1();
    forced++;
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    clk1();
    clk1();
    chk("rst_reg_we", reg_we_o, 0);
    chk("rst_waddr", reg_waddr_o, 0);
    chk("rst_wdata", reg_wdata_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_lu_ready", lu_ready, 1);
    chk("rst_perf", perf_stall_cnt_o, 0);
    rst = 1'b0;
    clk1();

    // Minimum buffer path: accept N, write visible N+2.
    lu_valid = 1'b1;
    lu_rd    = 5'd3;
    lu_wdata = 32'hDEAD0001;
    expect_wr(5'd3, 32'hDEAD0001);
    clk1();
    idle_in();
    chk("path_busy_n1", busy_o, 1);
    chk("path_ready_n1", lu_ready, 0);
    chk("path_we_n1", reg_we_o, 0);
    clk1();
    chk("path_we_n2", reg_we_o, 1);
    chk("path_ready_n2", lu_ready, 1);
    clk1();

    starve(32'h0000_0900);
    starve(32'h0000_1900);
    starve(32'h0000_2900);
`ifdef WB_ARB_PERF_EN
    chk("perf_count", perf_stall_cnt_o, forced);
`else
    chk("perf_count", perf_stall_cnt_o, 0);
`endif

    // WAW: younger pipeline write to the buffered rd drops the buffered value.
    lu_valid = 1'b1;
    lu_rd    = 5'd6;
    lu_wdata = 32'h11;
    clk1();
    idle_in();
    chk("waw_busy_loaded", busy_o, 1);
    wb_regwe = 1'b1;
    wb_rd    = 5'd6;
    wb_wdata = 32'h22;
    expect_wr(5'd6, 32'h22);
    clk1();
    idle_in();
    chk("waw_busy_cleared", busy_o, 0);
    chk("waw_no_stall", stall_o, 0);
    clk1();
    clk1();

    // rd=0 from the long unit is consumed and dropped.
    lu_valid = 1'b1;
    lu_rd    = 5'd0;
    lu_wdata = 32'hBAD;
    clk1();
    idle_in();
    chk("rd0_busy", busy_o, 0);
    chk("rd0_ready", lu_ready, 1);
    clk1();
    chk("rd0_no_write", reg_we_o, 0);
    clk1();

    // Simultaneous accept and pipeline write in IDLE.
    wb_regwe = 1'b1;
    wb_rd    = 5'd8;
    wb_wdata = 32'h88;
    lu_valid = 1'b1;
    lu_rd    = 5'd4;
    lu_wdata = 32'h44;
    expect_wr(5'd8, 32'h88);
    expect_wr(5'd4, 32'h44);
    clk1();
    idle_in();
    chk("simul_busy", busy_o, 1);
    clk1();
    clk1();
    chk("simul_busy_after", busy_o, 0);

    // Reset mid-WAIT discards the buffered rd=7.
    lu_valid = 1'b1;
    lu_rd    = 5'd7;
    lu_wdata = 32'h77;
    clk1();
    idle_in();
    chk("midrst_busy_before", busy_o, 1);
    rst = 1'b1;
    clk1();
    chk("midrst_busy", busy_o, 0);
    chk("midrst_ready", lu_ready, 1);
    chk("midrst_we", reg_we_o, 0);
    chk("midrst_stall", stall_o, 0);
    rst = 1'b0;
    clk1();
    clk1();
    chk("midrst_no_write", reg_we_o, 0);
    clk1();
    clk1();

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
